// File: rtl/reg_dump_reader.sv
// Read-side dump engine for the register file: walks first_addr..last_addr,
// snapshots each word and streams it out over a valid/ready handshake.
module reg_dump_reader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] cur_r;
  logic [ADDR_W-1:0] end_r;
  logic              abort_pend_r;
  logic              pend_eff_s;
  logic [ADDR_W-1:0] next_addr_s;

  // An abort arriving on the same edge as a decision counts as already pending.
  always_comb begin
    pend_eff_s  = abort_pend_r | abort;
    next_addr_s = cur_r + {{(ADDR_W-1){1'b0}}, 1'b1};
  end

  // Dump sequencer; rd_addr is kept equal to cur_r whenever FETCH is entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      cur_r        <= {ADDR_W{1'b0}};
      end_r        <= {ADDR_W{1'b0}};
      abort_pend_r <= 1'b0;
      rd_addr      <= {ADDR_W{1'b0}};
      out_valid    <= 1'b0;
      out_data     <= {DATA_W{1'b0}};
      out_addr     <= {ADDR_W{1'b0}};
      out_last     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
      err          <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            if (first_addr <= last_addr) begin
              cur_r   <= first_addr;
              end_r   <= last_addr;
              rd_addr <= first_addr;
              busy    <= 1'b1;
              state_r <= FETCH;
            end else begin
              err <= 1'b1;
            end
          end
        end
        FETCH: begin
          abort_pend_r <= pend_eff_s;
          if (pend_eff_s) begin
            done    <= 1'b1;
            aborted <= 1'b1;
            state_r <= DONE;
          end else begin
            out_data  <= rd_data;
            out_addr  <= cur_r;
            out_last  <= (cur_r == end_r);
            out_valid <= 1'b1;
            state_r   <= SEND;
          end
        end
        SEND: begin
          abort_pend_r <= pend_eff_s;
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_last || pend_eff_s) begin
              done    <= 1'b1;
              aborted <= pend_eff_s;
              state_r <= DONE;
            end else begin
              cur_r   <= next_addr_s;
              rd_addr <= next_addr_s;
              state_r <= FETCH;
            end
          end
        end
        DONE: begin
          abort_pend_r <= 1'b0;
          aborted      <= 1'b0;
          busy         <= 1'b0;
          state_r      <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/reg_dump_reader.md
Name: reg_dump_reader

Overview:
- Sequential read-side engine for the 32-entry register file.
- On `start`, walks register addresses `first_addr..last_addr`. For each address it drives the file's read address, captures the word and streams it out over a valid/ready handshake.
- Used for debug dumps and state export. It never writes the register file.

Parameters:
- ADDR_W, 5, register address width (32 registers).
- DATA_W, 32, register data width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  begin a dump; sampled only in IDLE.
- abort  input  1  terminate the dump early.
- first_addr  input  ADDR_W  first register to read; sampled with start.
- last_addr  input  ADDR_W  last register to read (inclusive); sampled with start.
- rd_addr  output  ADDR_W  read address to the register file.
- rd_data  input  DATA_W  combinational read data for rd_addr.
- out_valid  output  1  out_data/out_addr/out_last are valid.
- out_ready  input  1  consumer accepts the beat when high with out_valid.
- out_data  output  DATA_W  captured register word.
- out_addr  output  ADDR_W  address of out_data.
- out_last  output  1  beat is the final word of a dump.
- busy  output  1  high in any state except IDLE.
- done  output  1  one-cycle pulse at end of dump (normal or aborted).
- aborted  output  1  valid with done; 1 = dump ended by abort.
- err  output  1  one-cycle pulse: start rejected because first_addr > last_addr.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all outputs 0, including rd_addr, out_data and out_addr. Internal current/last address and abort_pend are 0. Reset overrides any in-flight beat; no handshake completion is implied.
- States: IDLE, FETCH, SEND, DONE.
- IDLE:
  - start=1 and first_addr<=last_addr: latch cur=first_addr, end=last_addr; go to FETCH.
  - start=1 and first_addr>last_addr: pulse err for 1 cycle, stay IDLE.
- FETCH:
  - rd_addr=cur.
  - At the edge: out_data<=rd_data, out_addr<=cur, out_last<=(cur==end); go to SEND.
  - If abort_pend or abort is set: go to DONE with aborted=1 instead, and capture nothing.
- SEND:
  - out_valid=1.
  - Beat completes on the edge where out_valid && out_ready.
  - out_valid, out_data, out_addr and out_last are stable until accepted; out_valid never drops without acceptance.
  - On completion: if out_last or abort_pend, go to DONE; else cur<=cur+1 and go to FETCH.
- DONE: done=1 for exactly one cycle; aborted=abort_pend; clear abort_pend; go to IDLE.
- abort handling:
  - Any abort pulse while busy sets abort_pend.
  - In SEND, the current beat completes normally (out_last unchanged), then DONE.
  - abort in IDLE is ignored.
- Ignored inputs: start while busy is ignored; first_addr and last_addr are used only when sampled with start.
- Latency and throughput:
  - start edge -> FETCH next cycle -> out_valid asserted the cycle after.
  - Maximum throughput is 1 word per 2 cycles.
  - An N-word dump with out_ready tied high takes 2N+1 cycles from the start edge to the done pulse.
- Snapshot semantics: the captured word is the register value at the FETCH edge. A register-file write on that same edge is not seen (pre-write value). Later writes do not alter the held out_data.
- Address arithmetic: cur never increments past end, so no wrap. first=0,last=31 dumps all 32 registers; R31 carries out_last=1.
- Outputs outside SEND: rd_addr holds its last value; out_valid=0.

Test Plan:
- Preload R0..R3 = 0x11111111, 0x22222222, 0x33333333, 0x44444444; start first=0,last=3, out_ready=1 -> 4 beats with out_addr 0..3 and matching data. out_last only on addr 3. done (aborted=0) 9 cycles after start.
- Same dump with out_ready low for 3 cycles in each SEND -> valid held stable through stalls, no beat lost or duplicated, order 0..3 preserved.
- first=last=7, R7=0xDEADBEEF -> single beat with out_last=1, then done. first=9,last=4 -> err pulse, busy stays 0, no out_valid.
- Dump 0..31; pulse abort during the SEND of addr 5 with out_ready=0 -> beat 5 still delivered once ready rises; no addr 6; done with aborted=1. Repeat with abort during FETCH -> no further beat, done with aborted=1.
- Write R2 0xAAAA0000->0x5555FFFF on the same edge as FETCH of addr 2 -> out_data=0xAAAA0000.
- Assert rst low mid-SEND -> all outputs 0 immediately without a clock. After release, a new start works normally; start asserted while busy has no effect.
